// File: rtl/vreg_file.sv
// vreg_file: RVV vector register file with byte-enable writes, three registered read
// ports, a pending-write scoreboard and a v0 tap. Define VRF_BYPASS_EN for write-to-read forwarding.
module vreg_file #(
  parameter int VLEN = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        rd_en_i,
  input  logic [4:0]        rd_addr0_i,
  input  logic [4:0]        rd_addr1_i,
  input  logic [4:0]        rd_addr2_i,
  output logic [VLEN-1:0]   rd_data0_o,
  output logic [VLEN-1:0]   rd_data1_o,
  output logic [VLEN-1:0]   rd_data2_o,
  output logic [2:0]        rd_valid_o,
  output logic [2:0]        rd_hazard_o,
  input  logic              wr_en_i,
  input  logic [4:0]        wr_addr_i,
  input  logic [VLEN/8-1:0] wr_be_i,
  input  logic [VLEN-1:0]   wr_data_i,
  input  logic              wr_last_i,
  input  logic              rsv_en_i,
  input  logic [4:0]        rsv_addr_i,
  output logic              rsv_err_o,
  output logic [31:0]       busy_o,
  output logic [VLEN-1:0]   v0_o
);
  localparam int NREGS = 32;
  localparam int BE_W  = VLEN / 8;

  logic [VLEN-1:0]  r_mem [NREGS];
  logic [VLEN-1:0]  r_rd_data [3];
  logic [2:0]       r_rd_valid;
  logic [NREGS-1:0] r_busy;
  logic             r_rsv_err;

  logic [4:0]       w_rd_addr [3];
  logic [VLEN-1:0]  w_rd_word [3];
  logic [VLEN-1:0]  w_wr_mask;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;

  assign w_rd_addr[0] = rd_addr0_i;
  assign w_rd_addr[1] = rd_addr1_i;
  assign w_rd_addr[2] = rd_addr2_i;

  always_comb begin
    w_wr_mask = '0;
    for (int b = 0; b < BE_W; b++) begin
      w_wr_mask[8*b +: 8] = {8{wr_be_i[b]}};
    end
  end

  // Read word selection and advisory hazard flags
  always_comb begin
    for (int k = 0; k < 3; k++) begin
`ifdef VRF_BYPASS_EN
      if (wr_en_i && (wr_addr_i == w_rd_addr[k])) begin
        w_rd_word[k] = (wr_data_i & w_wr_mask) | (r_mem[w_rd_addr[k]] & ~w_wr_mask);
      end else begin
        w_rd_word[k] = r_mem[w_rd_addr[k]];
      end
      rd_hazard_o[k] = rd_en_i[k] & r_busy[w_rd_addr[k]]
                       & ~(wr_en_i & wr_last_i & (wr_addr_i == w_rd_addr[k]));
`else
      w_rd_word[k]   = r_mem[w_rd_addr[k]];
      rd_hazard_o[k] = rd_en_i[k] & r_busy[w_rd_addr[k]];
`endif
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (rsv_en_i) w_set[rsv_addr_i] = 1'b1;
    if (wr_en_i && wr_last_i) w_clr[wr_addr_i] = 1'b1;
  end

  // Storage: byte-masked merge of write data into the addressed entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NREGS; n++) r_mem[n] <= '0;
    end else if (wr_en_i) begin
      r_mem[wr_addr_i] <= (wr_data_i & w_wr_mask) | (r_mem[wr_addr_i] & ~w_wr_mask);
    end
  end

  // Registered read ports; data holds while a port is idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) r_rd_data[k] <= '0;
      r_rd_valid <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (rd_en_i[k]) r_rd_data[k] <= w_rd_word[k];
      end
      r_rd_valid <= rd_en_i;
    end
  end

  // Scoreboard: a reserve beats a release of the same register in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy    <= '0;
      r_rsv_err <= 1'b0;
    end else begin
      r_busy    <= w_set | (r_busy & ~w_clr);
      r_rsv_err <= rsv_en_i & r_busy[rsv_addr_i] & ~w_clr[rsv_addr_i];
    end
  end

  assign rd_data0_o = r_rd_data[0];
  assign rd_data1_o = r_rd_data[1];
  assign rd_data2_o = r_rd_data[2];
  assign rd_valid_o = r_rd_valid;
  assign rsv_err_o  = r_rsv_err;
  assign busy_o     = r_busy;
  assign v0_o       = r_mem[0];

endmodule

// File: tb/tb_vreg_file.sv
// tb_vreg_file: directed and randomized checks of vreg_file against a behavioural model.
module tb_vreg_file;
  localparam int VLEN = 128;
  localparam int BE_W = VLEN / 8;

  logic            clk;
  logic            rst;
  logic [2:0]      rd_en;
  logic [4:0]      rd_addr [3];
  logic [VLEN-1:0] rd_data [3];
  logic [2:0]      rd_valid;
  logic [2:0]      rd_hazard;
  logic            wr_en;
  logic [4:0]      wr_addr;
  logic [BE_W-1:0] wr_be;
  logic [VLEN-1:0] wr_data;
  logic            wr_last;
  logic            rsv_en;
  logic [4:0]      rsv_addr;
  logic            rsv_err;
  logic [31:0]     busy;
  logic [VLEN-1:0] v0;

  vreg_file #(.VLEN(VLEN)) dut (
    .clk(clk), .rst(rst),
    .rd_en_i(rd_en),
    .rd_addr0_i(rd_addr[0]), .rd_addr1_i(rd_addr[1]), .rd_addr2_i(rd_addr[2]),
    .rd_data0_o(rd_data[0]), .rd_data1_o(rd_data[1]), .rd_data2_o(rd_data[2]),
    .rd_valid_o(rd_valid), .rd_hazard_o(rd_hazard),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_be_i(wr_be), .wr_data_i(wr_data),
    .wr_last_i(wr_last), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
    .rsv_err_o(rsv_err), .busy_o(busy), .v0_o(v0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [VLEN-1:0] m_mem [32];
  logic [VLEN-1:0] m_rd [3];
  logic [2:0]      m_vld;
  logic [31:0]     m_busy;
  logic            m_err;
  logic            m_release;
  logic [VLEN-1:0] m_val;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = '0;
      for (int k = 0; k < 3; k++) m_rd[k] = '0;
      m_vld  = '0;
      m_busy = '0;
      m_err  = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (rd_en[k]) begin
          m_val = m_mem[rd_addr[k]];
`ifdef VRF_BYPASS_EN
          if (wr_en && wr_addr == rd_addr[k])
            for (int b = 0; b < BE_W; b++)
              if (wr_be[b]) m_val[8*b +: 8] = wr_data[8*b +: 8];
`endif
          m_rd[k] = m_val;
        end
        m_vld[k] = rd_en[k];
      end
      if (wr_en)
        for (int b = 0; b < BE_W; b++)
          if (wr_be[b]) m_mem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
      m_release = wr_en && wr_last;
      m_err = rsv_en && m_busy[rsv_addr] && !(m_release && wr_addr == rsv_addr);
      if (m_release) m_busy[wr_addr] = 1'b0;
      if (rsv_en) m_busy[rsv_addr] = 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic exp_haz(int k);
    logic h;
    h = rd_en[k] & m_busy[rd_addr[k]];
`ifdef VRF_BYPASS_EN
    if (wr_en && wr_last && wr_addr == rd_addr[k]) h = 1'b0;
`endif
    return h;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd_data%0d", k), rd_data[k], m_rd[k]);
      chk($sformatf("rd_valid%0d", k), VLEN'(rd_valid[k]), VLEN'(m_vld[k]));
      chk($sformatf("rd_hazard%0d", k), VLEN'(rd_hazard[k]), VLEN'(exp_haz(k)));
    end
    chk("busy", VLEN'(busy), VLEN'(m_busy));
    chk("rsv_err", VLEN'(rsv_err), VLEN'(m_err));
    chk("v0", v0, m_mem[0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_en = '0; wr_en = 1'b0; wr_last = 1'b0; rsv_en = 1'b0;
    wr_be = '0; wr_data = '0; wr_addr = '0; rsv_addr = '0;
    for (int k = 0; k < 3; k++) rd_addr[k] = '0;
  endtask

  function automatic logic [VLEN-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [VLEN-1:0] pat;

  initial begin
    rst = 1'b0;
    idle();
    #1 rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Preload, then reset for two cycles
    wr_en = 1'b1; wr_be = '1; wr_addr = 5'd0; wr_data = rnd128();
    step();
    wr_addr = 5'd5; wr_data = rnd128();
    step();
    wr_addr = 5'd1; wr_data = rnd128();
    step();
    idle();
    rst = 1'b1;
    step(); step();
    chk("lit_busy_rst", VLEN'(busy), '0);
    chk("lit_v0_rst", v0, '0);
    rst = 1'b0;
    rd_en = 3'b111; rd_addr[0] = 5'd0; rd_addr[1] = 5'd5; rd_addr[2] = 5'd1;
    step();
    idle();
    chk("lit_rdv_after_rst", VLEN'(rd_valid), VLEN'(3'b111));
    chk("lit_rd5_after_rst", rd_data[1], '0);

    // Byte-enable write of v5
    pat = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    wr_en = 1'b1; wr_addr = 5'd5; wr_be = '1; wr_data = pat;
    step();
    wr_be = 16'h0003; wr_data = '1;
    step();
    idle();
    rd_en = 3'b010; rd_addr[1] = 5'd5;
    step();
    idle();
    chk("lit_v5_merge", rd_data[1], 128'h0F0E0D0C_0B0A0908_07060504_0302FFFF);
    chk("lit_v5_valid", VLEN'(rd_valid), VLEN'(3'b010));
    step();
    chk("lit_v5_valid_drop", VLEN'(rd_valid), '0);
    chk("lit_v5_hold", rd_data[1], 128'h0F0E0D0C_0B0A0908_07060504_0302FFFF);

    // Reserve, hazard and release of v3
    rsv_en = 1'b1; rsv_addr = 5'd3;
    step();
    idle();
    chk("lit_busy3_set", VLEN'(busy[3]), VLEN'(1'b1));
    rd_en = 3'b001; rd_addr[0] = 5'd3;
    #1;
    chk("lit_haz3", VLEN'(rd_hazard[0]), VLEN'(1'b1));
    step();
    idle();
    wr_en = 1'b1; wr_addr = 5'd3; wr_be = '1; wr_data = rnd128();
    step();
    idle();
    chk("lit_busy3_nolast", VLEN'(busy[3]), VLEN'(1'b1));
    wr_en = 1'b1; wr_addr = 5'd3; wr_be = '0; wr_last = 1'b1;
    step();
    idle();
    chk("lit_busy3_clr", VLEN'(busy[3]), '0);

    // Back-to-back reserve/release of v7, then double reserve
    rsv_en = 1'b1; rsv_addr = 5'd7;
    step();
    wr_en = 1'b1; wr_addr = 5'd7; wr_be = '1; wr_data = rnd128(); wr_last = 1'b1;
    step();
    idle();
    chk("lit_busy7_kept", VLEN'(busy[7]), VLEN'(1'b1));
    chk("lit_err7_none", VLEN'(rsv_err), '0);
    rsv_en = 1'b1; rsv_addr = 5'd7;
    step();
    idle();
    chk("lit_err7_pulse", VLEN'(rsv_err), VLEN'(1'b1));
    step();
    chk("lit_err7_end", VLEN'(rsv_err), '0);
    chk("lit_busy7_stay", VLEN'(busy[7]), VLEN'(1'b1));

    // Same-cycle read and write of v9
    wr_en = 1'b1; wr_addr = 5'd9; wr_be = '1; wr_data = {16{8'hAA}};
    rd_en = 3'b001; rd_addr[0] = 5'd9;
    step();
    idle();
`ifdef VRF_BYPASS_EN
    chk("lit_v9_rw", rd_data[0], {16{8'hAA}});
`else
    chk("lit_v9_rw", rd_data[0], '0);
`endif
    rd_en = 3'b100; rd_addr[2] = 5'd9;
    step();
    idle();
    chk("lit_v9_after", rd_data[2], {16{8'hAA}});

    // Asynchronous reset in the middle of a v0 write burst
    wr_en = 1'b1; wr_addr = 5'd0; wr_be = '1; wr_data = rnd128() | 128'h1;
    step();
    chk("lit_v0_written", VLEN'(v0 != '0), VLEN'(1'b1));
    wr_data = rnd128(); wr_be = 16'h00F0;
    #2 rst = 1'b1;
    #1;
    chk("lit_v0_async", v0, '0);
    idle();
    step();
    rst = 1'b0;
    step();
    chk("lit_v0_after_rst", v0, '0);

    // Randomized traffic on a narrow address window to force collisions
    for (int i = 0; i < 3000; i++) begin
      rd_en = 3'($urandom());
      for (int k = 0; k < 3; k++) rd_addr[k] = 5'($urandom_range(0, 7));
      wr_en    = ($urandom_range(0, 1) == 1);
      wr_addr  = 5'($urandom_range(0, 7));
      wr_be    = 16'($urandom());
      wr_data  = rnd128();
      wr_last  = ($urandom_range(0, 1) == 1);
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vreg_file.md
Name: vreg_file

Overview:
Vector register file for the RVV datapath. Successor of the scalar integer register file, generalised to VLEN-bit entries. Adds byte-enable writes, registered 3-port reads with valid flags, a per-register pending-write scoreboard, and a dedicated v0 mask tap. Sits between vector issue (reserve/hazard check) and the vector execute/writeback stages.

Parameters:
VLEN, 128, bits per vector register; multiple of 8, minimum 32
NREGS, 32, number of architectural registers; fixed at 32, addressed by 5 bits
BE_W, VLEN/8, byte-enable width; derived, not overridable

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-high
rd_en_i  in  3  per-port read request (port 0 = vs1, 1 = vs2, 2 = vd/old)
rd_addr0_i, rd_addr1_i, rd_addr2_i  in  5 each  read addresses
rd_data0_o, rd_data1_o, rd_data2_o  out  VLEN each  registered read data
rd_valid_o  out  3  per-port read data valid
rd_hazard_o  out  3  combinational: rd_en_i[k] & busy[rd_addrk_i]
wr_en_i  in  1  write strobe
wr_addr_i  in  5  write address
wr_be_i  in  BE_W  byte enables; bit b covers data bits [8b+7:8b]
wr_data_i  in  VLEN  write data
wr_last_i  in  1  final write of the owning instruction; releases scoreboard
rsv_en_i  in  1  reserve destination register at issue
rsv_addr_i  in  5  register to reserve
rsv_err_o  out  1  one-cycle pulse: reserve of an already-busy register
busy_o  out  32  scoreboard, bit n = register n has a pending write
v0_o  out  VLEN  current contents of v0, unregistered tap of storage

Behaviour:
- Reset (rst high, async): all 32 registers <= 0; busy_o = 0; rd_data*_o = 0; rd_valid_o = 0; rsv_err_o = 0. Reset mid-write discards the write. Reads in the cycle reset deasserts are accepted normally.
- v0 is an ordinary writable register (no hardwired zero). v0_o reflects storage and updates the cycle after a v0 write.
- Read: latency 1. On edge t, for each k with rd_en_i[k]=1: rd_data_k <= reg[rd_addr_k], rd_valid_o[k] <= 1. When rd_en_i[k]=0: rd_valid_o[k] <= 0 and rd_data_k holds its previous value. Ports are independent. The same address on several ports is legal.
- Write: on edge with wr_en_i=1, for each b with wr_be_i[b]=1, reg[wr_addr][8b+7:8b] <= wr_data_i[8b+7:8b]. Disabled bytes are unchanged. wr_be_i=0 writes nothing but still honours wr_last_i.
- Read and write to the same address in the same cycle: the read returns the pre-write value (see Optional Feature).
- Scoreboard next-state per bit n:
  - set = rsv_en_i & (rsv_addr_i==n)
  - clr = wr_en_i & wr_last_i & (wr_addr_i==n)
  - busy[n] <= set | (busy[n] & ~clr). When set and clr hit the same register in the same cycle, set wins (back-to-back producers).
- rsv_err_o <= rsv_en_i & busy[rsv_addr_i] & ~clr_same. The pulse lasts one cycle and busy stays 1.
- Release of a non-busy register is ignored silently. Writes without wr_last_i never change busy.
- rd_hazard_o is purely combinational from the current busy state. It is advisory: reads are never blocked by the register file.

Optional Feature:
VRF_BYPASS_EN:
- Defined: a read whose address matches an enabled write in the same cycle returns the merged data. Bytes with wr_be_i set come from wr_data_i; all other bytes come from storage. rd_hazard_o[k] is also masked to 0 when that same-cycle write carries wr_last_i.
- Undefined: the read returns the old data and rd_hazard_o is unmasked. Adds no logic on the read path.

Test Plan:
- Reset with storage preloaded: assert rst for 2 cycles -> every read returns 0, busy_o=0, rd_valid_o=0, v0_o=0.
- Write v5=0x...0F0E0D0C_0B0A0908_07060504_03020100 (wr_be all ones), then a write with wr_be=16'h0003 and data all 0xFF -> reading v5 gives low two bytes 0xFF, rest unchanged; rd_valid pulses exactly 1 cycle after rd_en.
- Reserve v3, check hazard, then release:
  - rsv v3 -> busy_o[3]=1; read v3 -> rd_hazard=1.
  - Write v3 without wr_last -> busy stays 1.
  - Write v3 with wr_last -> busy_o[3]=0 on the next cycle.
- Same-cycle reserve and release of v7 while busy -> busy_o[7] stays 1 and rsv_err_o=0. A second reserve of v7 alone -> rsv_err_o pulses once.
- Same-cycle read and write of v9 (old 0, new 0xAA.., be all ones) -> 0 without VRF_BYPASS_EN, 0xAA.. with it.
- Assert rst asynchronously mid-write burst to v0 -> v0_o=0 immediately and no partial bytes remain after rst deasserts.
